// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller slice.
//   addr_bits  : RAM address width for a given depth
//   level_bits : width needed to count DEPTH RAM words + in-flight read + 2 buffered words
package fifo_pkg;

    // Entries in the prefetch buffer that hides the RAM read latency.
    localparam int unsigned BUF_ENTRIES = 2;

    function automatic int unsigned addr_bits(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned level_bits(input int unsigned depth);
        return $clog2(depth + 3);
    endfunction

endpackage

// File: rtl/fifo_prefetch_buf.sv
// Two-entry prefetch buffer holding words already read from the RAM.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   flush           : synchronous clear of head/tail/count
//   cap_valid       : RAM read data arrives this cycle (capture at the edge)
//   cap_data        : RAM read data
//   out_ready       : downstream accepts the head word
//   out_valid       : buffer holds at least one word
//   out_data        : head word
//   buf_cnt         : words held (0..2)
//   space           : slots free after this cycle's pop (0..2)
module fifo_prefetch_buf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             cap_valid,
    input  logic [WIDTH-1:0] cap_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       buf_cnt,
    output logic [1:0]       space
);

    logic [WIDTH-1:0] data_q [BUF_ENTRIES];
    logic             head_q;
    logic             tail_q;
    logic [1:0]       cnt_q;
    logic             pop;

    assign pop       = out_valid & out_ready;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = data_q[head_q];
    assign buf_cnt   = cnt_q;
    // A pop this cycle frees a slot for a read issued this cycle.
    assign space     = 2'd2 - cnt_q + {1'b0, pop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else if (flush) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (cap_valid) begin
                tail_q <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            cnt_q <= cnt_q + {1'b0, cap_valid} - {1'b0, pop};
        end
    end

    // Storage is not reset; out_valid qualifies it.
    always_ff @(posedge clk) begin
        if (cap_valid && !flush) begin
            data_q[tail_q] <= cap_data;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller in front of an external FifoRam with 1-cycle read latency.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   flush                           : synchronous clear of all contents
//   in_valid/in_ready/in_data       : upstream stream
//   out_valid/out_ready/out_data    : downstream stream
//   level                           : words held (RAM + in-flight read + prefetch buffer)
//   ram_wen/ram_waddr/ram_wdata     : FifoRam write port
//   ram_ren/ram_raddr/ram_rdata     : FifoRam read port (data valid the cycle after ram_ren)
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned ABITS = addr_bits(DEPTH),
    parameter int unsigned LBITS = level_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LBITS-1:0] level,
    output logic             ram_wen,
    output logic [ABITS-1:0] ram_waddr,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_ren,
    output logic [ABITS-1:0] ram_raddr,
    input  logic [WIDTH-1:0] ram_rdata
);

    logic [ABITS:0] wptr_q;
    logic [ABITS:0] rptr_q;
    logic [ABITS:0] ram_cnt;
    logic           rd_pend_q;
    logic           push;
    logic [1:0]     buf_cnt;
    logic [1:0]     space;

    // Pointers carry a wrap bit, so the difference is the RAM occupancy 0..DEPTH and
    // the MSB alone indicates a full RAM.
    assign ram_cnt   = wptr_q - rptr_q;
    assign in_ready  = !reset && !flush && !ram_cnt[ABITS];
    assign push      = in_valid && in_ready;

    assign ram_wen   = push;
    assign ram_waddr = wptr_q[ABITS-1:0];
    assign ram_wdata = in_data;

    // Issue only if the word will have a buffer slot when it lands next edge.
    assign ram_ren   = (ram_cnt != '0) && !flush && (space > {1'b0, rd_pend_q});
    assign ram_raddr = rptr_q[ABITS-1:0];

    assign level = LBITS'(ram_cnt) + LBITS'(rd_pend_q) + LBITS'(buf_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_pend_q <= 1'b0;
        end else if (flush) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (ram_ren) begin
                rptr_q <= rptr_q + 1'b1;
            end
            rd_pend_q <= ram_ren;
        end
    end

    fifo_prefetch_buf #(
        .WIDTH(WIDTH)
    ) u_prefetch_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .cap_valid (rd_pend_q),
        .cap_data  (ram_rdata),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .buf_cnt   (buf_cnt),
        .space     (space)
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a behavioural FifoRam alongside it.
module tb_fifo_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned ABITS = 3;
    localparam int unsigned LBITS = 4;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [LBITS-1:0] level;
    logic             ram_wen;
    logic [ABITS-1:0] ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_ren;
    logic [ABITS-1:0] ram_raddr;
    logic [WIDTH-1:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] sb_q[$];
    int               model_cnt = 0;
    int               max_level = 0;

    fifo_ctrl #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .ABITS(ABITS),
        .LBITS(LBITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .ram_wen   (ram_wen),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_ren   (ram_ren),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    // FifoRam: registered read, one cycle latency.
    logic [WIDTH-1:0] ram_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (ram_wen) ram_mem[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= ram_mem[ram_raddr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            model_cnt = 0;
            check("rst_level", 32'(level), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
        end else begin
            check("level", 32'(level), 32'(model_cnt));
            check("wen", 32'(ram_wen), 32'(in_valid && in_ready));
            if (32'(level) > 32'(max_level)) max_level = int'(level);
            if (flush) begin
                check("flush_ren", 32'(ram_ren), 32'd0);
                check("flush_in_ready", 32'(in_ready), 32'd0);
                sb_q.delete();
                model_cnt = 0;
            end else begin
                if (in_valid && in_ready) begin
                    sb_q.push_back(in_data);
                    model_cnt++;
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("pop_on_empty", 32'(out_valid), 32'd0);
                    end else begin
                        check("data", 32'(out_data), 32'(sb_q.pop_front()));
                        model_cnt--;
                    end
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_ram_wen", 32'(ram_wen), 32'd0);
        check("rst_ram_ren", 32'(ram_ren), 32'd0);
        reset = 1'b0;
        tick();

        // Single word latency.
        in_valid  = 1'b1;
        in_data   = 16'h00A1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("single_v0", 32'(out_valid), 32'd0);
        check("single_l0", 32'(level), 32'd1);
        tick();
        check("single_v1", 32'(out_valid), 32'd0);
        tick();
        check("single_v2", 32'(out_valid), 32'd1);
        check("single_d2", 32'(out_data), 32'h00A1);
        tick();
        check("single_v3", 32'(out_valid), 32'd0);
        check("single_l3", 32'(level), 32'd0);

        // Fill with backpressure; the 11th push must be refused.
        out_ready = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            check("fill_in_ready", 32'(in_ready), 32'(i <= 10));
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("fill_level", 32'(level), 32'd10);
        check("fill_in_ready_low", 32'(in_ready), 32'd0);

        // Drain without bubbles.
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_data", 32'(out_data), 32'(i));
            tick();
        end
        check("drain_empty", 32'(out_valid), 32'd0);
        check("drain_level", 32'(level), 32'd0);

        // Streaming 1000 words.
        max_level = 0;
        for (int i = 0; i < 1000; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h1000 + i);
            if (i >= 3) check("stream_no_bubble", 32'(out_valid), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("stream_done_valid", 32'(out_valid), 32'd0);
        check("stream_sb_empty", 32'(sb_q.size()), 32'd0);
        check("stream_max_level", 32'(max_level <= 3), 32'd1);

        // Random backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("rand_sb_empty", 32'(sb_q.size()), 32'd0);
        check("rand_level", 32'(level), 32'd0);

        // Flush with a read in flight at level 5.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h0500 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0555;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hDEAD;
        flush     = 1'b1;
        check("pre_flush_level", 32'(level), 32'd5);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_stale", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b1;
        in_data  = 16'h0C0D;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("post_flush_sb_empty", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h0700 + i);
            tick();
        end
        #1;
        reset = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_wen", 32'(ram_wen), 32'd0);
        check("arst_ren", 32'(ram_ren), 32'd0);
        tick();
        tick();
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 16'h0BEE;
        tick();
        in_valid = 1'b0;
        tick();
        check("bee_not_yet", 32'(out_valid), 32'd0);
        tick();
        check("bee_valid", 32'(out_valid), 32'd1);
        check("bee_data", 32'(out_data), 32'h0BEE);
        tick();
        tick();
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);
        check("final_level", 32'(level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
